matrix_stream_loader: RTL and testbench
=======================================

MATRIX_STREAM_LOADER -- requirements
Module: matrix_stream_loader

Interface
REQ-001 Parameter n, default 10: matrix dimension (n x n operands); n >= 2.
REQ-002 Localparam W = $clog2(n): width of every row/column index port.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low; sampled only on the rising edge of clk.
REQ-005 start  input  1  begin a load sequence; sampled in IDLE only.
REQ-006 s_data  input  32  operand word stream, row-major: all of A, then all of B.
REQ-007 s_valid  input  1  s_data valid.
REQ-008 s_ready  output  1  loader accepts s_data this cycle.
REQ-009 a_in  output  32  A write data.
REQ-010 a_i, a_j  output  W each  A write row and column.
REQ-011 a_we  output  1  A write enable.
REQ-012 b_in  output  32  B write data.
REQ-013 b_i, b_j  output  W each  B write row and column.
REQ-014 b_we  output  1  B write enable.
REQ-015 busy  output  1  high in LOAD_A or LOAD_B.
REQ-016 load_done  output  1  one-cycle pulse after the final B write.

Function
REQ-017 FSM states: IDLE, LOAD_A, LOAD_B, FLUSH, DONE.
REQ-018 IDLE: s_ready=0; start=1 -> LOAD_A with row/col counters cleared to 0.
REQ-019 LOAD_A/LOAD_B: s_ready=1; a handshake occurs when s_valid && s_ready.
REQ-020 Each handshake captures s_data and the current (row,col) into the write register; the write (a_we or b_we = 1, data and index driven) occurs in the next cycle, giving fixed one-cycle latency.
REQ-021 Counters advance on handshake only: col increments; at col==n-1, col wraps to 0 and row increments.
REQ-022 Handshake at (n-1,n-1) in LOAD_A -> LOAD_B with counters at 0; in LOAD_B -> FLUSH.
REQ-023 No handshake (s_valid=0) holds counters and state; a_we=b_we=0 in the following cycle.
REQ-024 FLUSH, one cycle: s_ready=0; the final B write (b_we=1) is issued -> DONE.
REQ-025 DONE, one cycle: load_done=1, s_ready=0 -> IDLE.
REQ-026 start is ignored outside IDLE; s_valid is ignored while s_ready=0.
REQ-027 a_we and b_we are never high in the same cycle; each is high for exactly n*n cycles per sequence.
REQ-028 The last A write and the first B handshake are permitted in the same cycle.
REQ-029 Outputs are registered; s_ready and busy are decoded from state only, with no combinational path from s_valid.
REQ-030 a_in/b_in and indices hold their last written values when the respective we is low.

Reset
REQ-031 rst=0 at a clock edge -> state IDLE; counters 0; a_we=b_we=0, load_done=0, s_ready=0, busy=0; a_in=b_in=0; all indices 0.
REQ-032 Reset mid-load aborts the sequence immediately: no further writes are issued and the pending write register is discarded.
REQ-033 While rst=0, start is ignored; after release, the next start begins a fresh sequence at (0,0) of A.

Verification
REQ-034 n=3, start, then 18 back-to-back words 1..18 -> a_we on 9 consecutive cycles writing A[0][0]=1..A[2][2]=9, then b_we writing B[0][0]=10..B[2][2]=18; load_done pulses once, one cycle after the final b_we.
REQ-035 n=3, s_valid toggled 1/0 on each word -> writes occur only the cycle after a valid word; indices still follow row-major order; total a_we count 9, b_we count 9.
REQ-036 n=3, s_valid=1 with data in IDLE without start -> s_ready=0; no writes; counters unchanged.
REQ-037 n=3, rst=0 asserted after the 5th B word -> next cycle outputs at reset values; new start plus 18 words reloads correctly from A[0][0].
REQ-038 n=3, start pulsed again during LOAD_B -> ignored; the sequence completes normally with exactly one load_done.
REQ-039 n=2, default-width check: W=1; the 4th A word -> a_i=1, a_j=1, then b_i=b_j=0 on the first B write.

Source files
------------

// File: rtl/matrix_stream_loader.sv
// Streams 2*n*n row-major words into the A then B operand memories, one
// registered write per accepted word, followed by a flush and a done pulse.
module matrix_stream_loader #(
    parameter int n = 10,
    localparam int W = $clog2(n)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [31:0]  a_in,
    output logic [W-1:0] a_i,
    output logic [W-1:0] a_j,
    output logic         a_we,
    output logic [31:0]  b_in,
    output logic [W-1:0] b_i,
    output logic [W-1:0] b_j,
    output logic         b_we,
    output logic         busy,
    output logic         load_done
);

    localparam logic [W-1:0] LAST = W'(n - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FLUSH, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   row_q, row_d;
    logic [W-1:0]   col_q, col_d;
    logic           loading;
    logic           hs;
    logic           last_elem;

    logic [31:0]    a_in_q, b_in_q;
    logic [W-1:0]   a_i_q, a_j_q, b_i_q, b_j_q;
    logic           a_we_q, b_we_q, load_done_q;

    assign hs        = s_valid && loading;
    assign last_elem = (row_q == LAST) && (col_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Counters move only on an accepted word; the final element of each
    // matrix rewinds them to (0,0) for the next phase.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            LOAD_A, LOAD_B: begin
                if (hs) begin
                    if (last_elem) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = (state_q == LOAD_A) ? LOAD_B : FLUSH;
                    end else if (col_q == LAST) begin
                        col_d = '0;
                        row_d = row_q + ONE;
                    end else begin
                        col_d = col_q + ONE;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        loading = (state_q == LOAD_A) || (state_q == LOAD_B);
        s_ready = loading;
        busy    = loading;
    end

    // Write register: captured on handshake, presented one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_we_q      <= 1'b0;
            b_we_q      <= 1'b0;
            load_done_q <= 1'b0;
            a_in_q      <= '0;
            a_i_q       <= '0;
            a_j_q       <= '0;
            b_in_q      <= '0;
            b_i_q       <= '0;
            b_j_q       <= '0;
        end else begin
            a_we_q      <= hs && (state_q == LOAD_A);
            b_we_q      <= hs && (state_q == LOAD_B);
            load_done_q <= (state_q == FLUSH);
            if (hs && (state_q == LOAD_A)) begin
                a_in_q <= s_data;
                a_i_q  <= row_q;
                a_j_q  <= col_q;
            end
            if (hs && (state_q == LOAD_B)) begin
                b_in_q <= s_data;
                b_i_q  <= row_q;
                b_j_q  <= col_q;
            end
        end
    end

    assign a_in      = a_in_q;
    assign a_i       = a_i_q;
    assign a_j       = a_j_q;
    assign a_we      = a_we_q;
    assign b_in      = b_in_q;
    assign b_i       = b_i_q;
    assign b_j       = b_j_q;
    assign b_we      = b_we_q;
    assign load_done = load_done_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: n=3 instance against a word-count model, plus an n=2 instance.
module tb_matrix_stream_loader;

    localparam int N  = 3;
    localparam int NN = N * N;
    localparam int W  = $clog2(N);
    localparam int VW = 69 + 4 * W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, s_valid, s_ready, a_we, b_we, busy, load_done;
    logic [31:0]  s_data, a_in, b_in;
    logic [W-1:0] a_i, a_j, b_i, b_j;

    matrix_stream_loader #(.n(N)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .a_in(a_in), .a_i(a_i), .a_j(a_j), .a_we(a_we),
        .b_in(b_in), .b_i(b_i), .b_j(b_j), .b_we(b_we), .busy(busy), .load_done(load_done)
    );

    logic         rst2, start2, s_valid2, s_ready2, a_we2, b_we2, busy2, load_done2;
    logic [31:0]  s_data2, a_in2, b_in2;
    logic [0:0]   a_i2, a_j2, b_i2, b_j2;

    matrix_stream_loader #(.n(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .s_data(s_data2), .s_valid(s_valid2),
        .s_ready(s_ready2), .a_in(a_in2), .a_i(a_i2), .a_j(a_j2), .a_we(a_we2),
        .b_in(b_in2), .b_i(b_i2), .b_j(b_j2), .b_we(b_we2), .busy(busy2), .load_done(load_done2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a sequence is active from start until two cycles after
    // the 2*n*n-th accepted word; word k goes to A (k<n*n) or B at row-major position.
    bit          m_act;
    int          m_k, m_post;
    bit          e_awe, e_bwe;
    logic [31:0] ea_in, eb_in;
    int          ea_i, ea_j, eb_i, eb_j;
    int          n_awe, n_bwe, n_done;

    function automatic logic [VW-1:0] obs();
        return {a_we, b_we, load_done, s_ready, busy, a_in, a_i, a_j, b_in, b_i, b_j};
    endfunction

    function automatic logic [VW-1:0] expv();
        logic [W-1:0] ai, aj, bi, bj;
        bit rdy, dn;
        ai  = W'(ea_i);
        aj  = W'(ea_j);
        bi  = W'(eb_i);
        bj  = W'(eb_j);
        rdy = m_act && (m_post == 0) && (m_k < 2 * NN);
        dn  = (m_post == 2);
        return {e_awe, e_bwe, dn, rdy, rdy, ea_in, ai, aj, eb_in, bi, bj};
    endfunction

    task automatic step(input bit st, input bit v, input logic [31:0] d);
        bit hs;
        rst = 1'b1; start = st; s_valid = v; s_data = d;
        hs = m_act && (m_post == 0) && (m_k < 2 * NN) && v;
        @(posedge clk);
        @(negedge clk);
        e_awe = 1'b0;
        e_bwe = 1'b0;
        if (!m_act) begin
            if (st) begin
                m_act = 1'b1; m_k = 0; m_post = 0;
            end
        end else if (m_post == 2) begin
            m_act = 1'b0; m_post = 0;
        end else if (m_post == 1) begin
            m_post = 2;
        end else if (hs) begin
            if (m_k < NN) begin
                e_awe = 1'b1; ea_in = d; ea_i = m_k / N; ea_j = m_k % N;
            end else begin
                e_bwe = 1'b1; eb_in = d; eb_i = (m_k - NN) / N; eb_j = (m_k - NN) % N;
            end
            m_k++;
            if (m_k == 2 * NN) m_post = 1;
        end
        n_awe  += int'(a_we);
        n_bwe  += int'(b_we);
        n_done += int'(load_done);
    endtask

    task automatic reset_cycle(input bit st, input bit v);
        rst = 1'b0; start = st; s_valid = v; s_data = $urandom;
        @(posedge clk);
        @(negedge clk);
        m_act = 1'b0; m_k = 0; m_post = 0;
        e_awe = 1'b0; e_bwe = 1'b0;
        ea_in = '0; eb_in = '0;
        ea_i = 0; ea_j = 0; eb_i = 0; eb_j = 0;
    endtask

    task automatic clear_counts();
        n_awe = 0; n_bwe = 0; n_done = 0;
    endtask

    task automatic test_reset();
        for (int r = 0; r < 2; r++) begin
            reset_cycle(1'b1, 1'b1);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_values got=%h expected=%h", obs(), expv());
            end
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, $urandom);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL post_reset_idle got=%h expected=%h", obs(), expv());
            end
        end
    endtask

    task automatic test_idle_ignore();
        clear_counts();
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 1'b1, $urandom);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL idle_ignore got=%h expected=%h", obs(), expv());
            end
        end
        checks++;
        if (n_awe + n_bwe !== 0) begin
            errors++;
            $display("FAIL idle_writes got=%0d expected=0", n_awe + n_bwe);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        step(1'b1, 1'b0, 32'd0);
        for (int w = 1; w <= 2 * NN + 3; w++) begin
            if (w <= 2 * NN) step(1'b0, 1'b1, 32'(w));
            else             step(1'b0, 1'b0, 32'hDEAD_BEEF);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL back_to_back w=%0d got=%h expected=%h", w, obs(), expv());
            end
        end
        checks++;
        if (n_awe !== NN || n_bwe !== NN || n_done !== 1) begin
            errors++;
            $display("FAIL b2b_counts got a=%0d b=%0d done=%0d expected 9/9/1", n_awe, n_bwe, n_done);
        end
    endtask

    task automatic test_toggle_valid();
        clear_counts();
        step(1'b1, 1'b0, 32'd0);
        for (int w = 0; w < 4 * NN + 3; w++) begin
            step(1'b0, (w % 2 == 0) && (w < 4 * NN), $urandom);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL toggle_valid w=%0d got=%h expected=%h", w, obs(), expv());
            end
        end
        checks++;
        if (n_awe !== NN || n_bwe !== NN || n_done !== 1) begin
            errors++;
            $display("FAIL toggle_counts got a=%0d b=%0d done=%0d expected 9/9/1", n_awe, n_bwe, n_done);
        end
    endtask

    task automatic test_reset_mid_load();
        step(1'b1, 1'b0, 32'd0);
        for (int w = 0; w < NN + 5; w++) step(1'b0, 1'b1, $urandom);
        reset_cycle(1'b1, 1'b1);
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_mid_load got=%h expected=%h", obs(), expv());
        end
        clear_counts();
        step(1'b1, 1'b0, 32'd0);
        for (int w = 1; w <= 2 * NN + 3; w++) begin
            step(1'b0, w <= 2 * NN, 32'(100 + w));
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reload w=%0d got=%h expected=%h", w, obs(), expv());
            end
        end
        checks++;
        if (n_awe !== NN || n_bwe !== NN || n_done !== 1) begin
            errors++;
            $display("FAIL reload_counts got a=%0d b=%0d done=%0d expected 9/9/1", n_awe, n_bwe, n_done);
        end
    endtask

    task automatic test_restart_ignored();
        clear_counts();
        step(1'b1, 1'b0, 32'd0);
        for (int w = 0; w < 2 * NN + 4; w++) begin
            step((w >= NN + 1) && (w <= NN + 5), w < 2 * NN, $urandom);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL restart_ignored w=%0d got=%h expected=%h", w, obs(), expv());
            end
        end
        checks++;
        if (n_done !== 1 || n_awe !== NN || n_bwe !== NN) begin
            errors++;
            $display("FAIL restart_counts got a=%0d b=%0d done=%0d expected 9/9/1", n_awe, n_bwe, n_done);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            step(($urandom % 6) == 0, ($urandom % 3) != 0, $urandom);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random c=%0d got=%h expected=%h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_n2();
        rst2 = 1'b0; start2 = 1'b1; s_valid2 = 1'b0; s_data2 = '0;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({a_we2, b_we2, s_ready2, busy2, a_i2, a_j2} !== 6'b0) begin
            errors++;
            $display("FAIL n2_reset got=%b expected=000000", {a_we2, b_we2, s_ready2, busy2, a_i2, a_j2});
        end
        rst2 = 1'b1;
        @(posedge clk); @(negedge clk);
        start2 = 1'b0; s_valid2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data2 = 32'(200 + k);
            @(posedge clk); @(negedge clk);
            if (k == 3) begin
                checks++;
                if ({a_we2, b_we2, a_i2, a_j2} !== 4'b1011 || a_in2 !== 32'd203) begin
                    errors++;
                    $display("FAIL n2_last_a got we/idx=%b data=%0d expected 1011 203", {a_we2, b_we2, a_i2, a_j2}, a_in2);
                end
            end
            if (k == 4) begin
                checks++;
                if ({a_we2, b_we2, b_i2, b_j2} !== 4'b0100 || b_in2 !== 32'd204) begin
                    errors++;
                    $display("FAIL n2_first_b got we/idx=%b data=%0d expected 0100 204", {a_we2, b_we2, b_i2, b_j2}, b_in2);
                end
            end
        end
        checks++;
        if ({b_we2, b_i2, b_j2, s_ready2} !== 4'b1110) begin
            errors++;
            $display("FAIL n2_flush got=%b expected=1110", {b_we2, b_i2, b_j2, s_ready2});
        end
        s_valid2 = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({load_done2, b_we2} !== 2'b10) begin
            errors++;
            $display("FAIL n2_done got=%b expected=10", {load_done2, b_we2});
        end
    endtask

    initial begin
        rst2 = 1'b0; start2 = 1'b0; s_valid2 = 1'b0; s_data2 = '0;
        m_act = 1'b0; m_k = 0; m_post = 0;
        clear_counts();
        test_reset();
        test_idle_ignore();
        test_back_to_back();
        test_toggle_valid();
        test_reset_mid_load();
        test_restart_ignored();
        test_random();
        test_n2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
